tmds_gearbox_ser: RTL and testbench

- Parametrised successor to the fixed 3-channel, 2-bits-per-clock TMDS shifter.
- Accepts one pre-encoded 10-bit TMDS symbol per channel through a valid/ready handshake and emits SER_W bits per channel per clk cycle.
- Generates a phase-aligned TMDS clock-channel pattern.
- Sits between the per-channel TMDS encoders and the output primitives (ODDR/OSERDES or direct pins).
- On handshake underflow, inserts a control symbol and flags the event instead of replaying stale data.

---
 rtl/tmds_gearbox_ser.sv | 126 ++++++++++++
 tb/tb_tmds_gearbox_ser.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_gearbox_ser.sv
// tmds_gearbox_ser
//
// TMDS serialiser gearbox. It takes one pre-encoded 10-bit symbol per data
// channel through a valid/ready handshake and emits SER_W bits per channel
// on every clk cycle. It also generates a TMDS clock-channel pattern that is
// phase-aligned with the data channels. If no symbol set is offered at a load
// slot, IDLE_SYM is sent in its place and the sticky underflow flag is set.
//
// Ports
//   clk            serial-word clock (TMDS bit rate / SER_W)
//   rst            synchronous, active-high reset
//   sym_in         channel k symbol in bits [10k+9:10k]
//   sym_valid      sym_in holds a valid symbol set
//   sym_ready      a new symbol set is taken at the next clk edge
//   ser_out        channel k word in bits [SER_W*k +: SER_W]; LSB is first in time
//   clk_out        clock-channel word, same bit ordering as ser_out
//   underflow      sticky: a load slot occurred with sym_valid low
//   clr_underflow  clears underflow (a new miss in the same cycle wins)
module tmds_gearbox_ser #(
  parameter int          NUM_CH    = 3,
  parameter int          SER_W     = 2,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic [9:0]  IDLE_SYM  = 10'b1101010100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*10-1:0]    sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic [NUM_CH*SER_W-1:0] ser_out,
  output logic [SER_W-1:0]        clk_out,
  output logic                    underflow,
  input  logic                    clr_underflow
);

  // Bit order applied to every value entering a shift register. The
  // registers always shift right, so reversing on load is all MSB_FIRST needs.
  function automatic logic [9:0] orient(input logic [9:0] v);
    logic [9:0] r;
    r = v;
    if (MSB_FIRST) begin
      for (int i = 0; i < 10; i++) begin
        r[i] = v[9-i];
      end
    end
    return r;
  endfunction

  localparam int             LOADS     = 10 / SER_W;
  localparam int             CNT_W     = (LOADS > 1) ? $clog2(LOADS) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LOADS - 1);
  localparam logic [9:0]     CLK_PAT   = 10'b0000011111;
  localparam logic [9:0]     CLK_LOAD  = orient(CLK_PAT);
  localparam logic [9:0]     IDLE_LOAD = orient(IDLE_SYM);

  generate
    if (!(SER_W == 1 || SER_W == 2 || SER_W == 5 || SER_W == 10)) begin : g_bad_ser_w
      $error("tmds_gearbox_ser: SER_W must be 1, 2, 5 or 10");
    end
  endgenerate

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0][9:0]  data_q, data_d;
  logic [9:0]              clk_q, clk_d;
  logic                    uf_q, uf_d;
  logic                    load;

  // Load slot is decoded from the phase register only, so sym_ready has
  // no combinational dependence on any input.
  assign load = (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    data_d = '0;
    clk_d  = clk_q;
    uf_d   = uf_q;

    if (load) begin
      cnt_d = '0;
      clk_d = CLK_LOAD;
      for (int k = 0; k < NUM_CH; k++) begin
        data_d[k] = sym_valid ? orient(sym_in[10*k +: 10]) : IDLE_LOAD;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      clk_d = clk_q >> SER_W;
      for (int k = 0; k < NUM_CH; k++) begin
        data_d[k] = data_q[k] >> SER_W;
      end
    end

    // A miss in the same cycle as a clear keeps the flag set.
    if (load && !sym_valid) begin
      uf_d = 1'b1;
    end else if (clr_underflow) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LAST;
      clk_q <= CLK_LOAD;
      uf_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k] <= IDLE_LOAD;
      end
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      clk_q  <= clk_d;
      uf_q   <= uf_d;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
      assign ser_out[SER_W*k +: SER_W] = data_q[k][SER_W-1:0];
    end
  endgenerate

  assign clk_out   = clk_q[SER_W-1:0];
  assign sym_ready = load;
  assign underflow = uf_q;

endmodule

// File: tb/tb_tmds_gearbox_ser.sv
`timescale 1ns/1ps
module tb_tmds_gearbox_ser;

  localparam logic [9:0] IDLE = 10'b1101010100;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] idle_v = IDLE;
  logic [9:0] clkp_v = 10'b0000011111;

  // Instance A: SER_W=2, LSB first
  logic [29:0] a_sym = '0;
  logic        a_valid = 1'b0, a_clr = 1'b0, a_ready, a_uf;
  logic [5:0]  a_ser;
  logic [1:0]  a_clk;

  // Instance B: SER_W=10
  logic [29:0] b_sym = '0;
  logic        b_valid = 1'b0, b_clr = 1'b0, b_ready, b_uf;
  logic [29:0] b_ser;
  logic [9:0]  b_clk;

  // Instance C: SER_W=1, MSB first
  logic [29:0] c_sym = '0;
  logic        c_valid = 1'b0, c_clr = 1'b0, c_ready, c_uf;
  logic [2:0]  c_ser;
  logic [0:0]  c_clk;

  tmds_gearbox_ser #(.NUM_CH(3), .SER_W(2), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .sym_in(a_sym), .sym_valid(a_valid), .sym_ready(a_ready),
    .ser_out(a_ser), .clk_out(a_clk), .underflow(a_uf), .clr_underflow(a_clr));

  tmds_gearbox_ser #(.NUM_CH(3), .SER_W(10), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .sym_in(b_sym), .sym_valid(b_valid), .sym_ready(b_ready),
    .ser_out(b_ser), .clk_out(b_clk), .underflow(b_uf), .clr_underflow(b_clr));

  tmds_gearbox_ser #(.NUM_CH(3), .SER_W(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .sym_in(c_sym), .sym_valid(c_valid), .sym_ready(c_ready),
    .ser_out(c_ser), .clk_out(c_clk), .underflow(c_uf), .clr_underflow(c_clr));

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  // Expected 3-channel 2-bit word for slice i of symbols s0..s2.
  function automatic logic [5:0] slice2(input logic [9:0] s0, input logic [9:0] s1,
                                        input logic [9:0] s2, input int i);
    return {s2[2*i +: 2], s1[2*i +: 2], s0[2*i +: 2]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
    rst = 1'b1;
    step();
    step();
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_a_ready got=%b exp=1", a_ready); end
    checks++; if (a_ser !== slice2(idle_v, idle_v, idle_v, 0)) begin failures++; $display("FAIL rst_a_ser got=%h exp=%h", a_ser, slice2(idle_v, idle_v, idle_v, 0)); end
    checks++; if (a_clk !== 2'b11) begin failures++; $display("FAIL rst_a_clk got=%b exp=11", a_clk); end
    checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL rst_a_uf got=%b exp=0", a_uf); end
    checks++; if (b_ser !== {IDLE, IDLE, IDLE}) begin failures++; $display("FAIL rst_b_ser got=%h", b_ser); end
    checks++; if (b_clk !== 10'h01F) begin failures++; $display("FAIL rst_b_clk got=%h exp=01f", b_clk); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%b exp=1", b_ready); end
    checks++; if (c_ser !== 3'b111) begin failures++; $display("FAIL rst_c_ser got=%b exp=111", c_ser); end
    checks++; if (c_clk !== 1'b0) begin failures++; $display("FAIL rst_c_clk got=%b exp=0", c_clk); end
    checks++; if (c_uf !== 1'b0) begin failures++; $display("FAIL rst_c_uf got=%b exp=0", c_uf); end
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [9:0] s [3];
    reset_all();
    a_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) begin s[0] = 10'h155; s[1] = 10'h2AA; s[2] = 10'h0F3; end
      else        begin s[0] = 10'h2B4; s[1] = 10'h001; s[2] = 10'h3C5; end
      a_sym = {s[2], s[1], s[0]};
      for (int i = 0; i < 5; i++) begin
        step();
        if (i != 4) a_sym = 30'h3FFF_FFFF ^ a_sym;
        checks++; if (a_ser !== slice2(s[0], s[1], s[2], i)) begin failures++; $display("FAIL stream_ser n=%0d i=%0d got=%h exp=%h", n, i, a_ser, slice2(s[0], s[1], s[2], i)); end
        checks++; if (a_clk !== clkp_v[2*i +: 2]) begin failures++; $display("FAIL stream_clk i=%0d got=%b exp=%b", i, a_clk, clkp_v[2*i +: 2]); end
        checks++; if (a_ready !== (i == 4)) begin failures++; $display("FAIL stream_ready i=%0d got=%b", i, a_ready); end
        checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL stream_uf i=%0d got=%b exp=0", i, a_uf); end
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_underflow();
    a_valid = 1'b0; a_clr = 1'b0;
    reset_all();
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL uf_first_ready got=%b exp=1", a_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (a_ser !== slice2(idle_v, idle_v, idle_v, i)) begin failures++; $display("FAIL uf_idle_ser i=%0d got=%h exp=%h", i, a_ser, slice2(idle_v, idle_v, idle_v, i)); end
      if (i == 0) begin
        checks++; if (a_uf !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", a_uf); end
        a_clr = 1'b1;
      end else begin
        checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL uf_clear i=%0d got=%b exp=0", i, a_uf); end
        a_clr = 1'b0;
      end
    end
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    checks++; if (a_uf !== 1'b1) begin failures++; $display("FAIL uf_set_wins got=%b exp=1", a_uf); end
    checks++; if (a_ser !== slice2(idle_v, idle_v, idle_v, 0)) begin failures++; $display("FAIL uf_set_wins_ser got=%h", a_ser); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] s [3];
    logic [9:0] p [3];
    s[0] = 10'h111; s[1] = 10'h222; s[2] = 10'h333;
    p[0] = 10'h0AB; p[1] = 10'h1CD; p[2] = 10'h3EF;
    reset_all();
    a_valid = 1'b1;
    a_sym = {s[2], s[1], s[0]};
    step(); step(); step();
    checks++; if (a_ser !== slice2(s[0], s[1], s[2], 2)) begin failures++; $display("FAIL mid_pre_ser got=%h exp=%h", a_ser, slice2(s[0], s[1], s[2], 2)); end
    a_sym = {p[2], p[1], p[0]};
    rst = 1'b1;
    step();
    checks++; if (a_ser !== slice2(idle_v, idle_v, idle_v, 0)) begin failures++; $display("FAIL mid_rst_ser got=%h", a_ser); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", a_ready); end
    checks++; if (a_clk !== 2'b11) begin failures++; $display("FAIL mid_rst_clk got=%b exp=11", a_clk); end
    a_valid = 1'b0;
    step();
    checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL mid_rst_uf got=%b exp=0", a_uf); end
    rst = 1'b0;
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (a_ser !== slice2(p[0], p[1], p[2], i)) begin failures++; $display("FAIL mid_post_ser i=%0d got=%h exp=%h", i, a_ser, slice2(p[0], p[1], p[2], i)); end
      checks++; if (a_ready !== (i == 4)) begin failures++; $display("FAIL mid_post_ready i=%0d got=%b", i, a_ready); end
      checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL mid_post_uf i=%0d got=%b exp=0", i, a_uf); end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_wide();
    logic [29:0] exp_w;
    reset_all();
    b_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      b_sym = {10'(10'h100 + j), 10'(10'h200 + j), 10'(j + 1)};
      exp_w = b_sym;
      step();
      checks++; if (b_ser !== exp_w) begin failures++; $display("FAIL wide_ser j=%0d got=%h exp=%h", j, b_ser, exp_w); end
      checks++; if (b_ser[9:0] !== 10'(j + 1)) begin failures++; $display("FAIL wide_ch0 j=%0d got=%h exp=%h", j, b_ser[9:0], 10'(j + 1)); end
      checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL wide_ready j=%0d got=%b exp=1", j, b_ready); end
      checks++; if (b_clk !== 10'h01F) begin failures++; $display("FAIL wide_clk j=%0d got=%h exp=01f", j, b_clk); end
    end
    b_valid = 1'b0;
    step();
    checks++; if (b_ser !== {IDLE, IDLE, IDLE}) begin failures++; $display("FAIL wide_idle got=%h", b_ser); end
    checks++; if (b_uf !== 1'b1) begin failures++; $display("FAIL wide_uf got=%b exp=1", b_uf); end
  endtask

  task automatic test_msb_first();
    logic [9:0] r0, r1, r2, rc;
    reset_all();
    c_valid = 1'b1;
    c_sym = {10'h155, 10'h0F3, 10'h200};
    r0 = rev10(10'h200); r1 = rev10(10'h0F3); r2 = rev10(10'h155);
    rc = rev10(clkp_v);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (c_ser !== {r2[i], r1[i], r0[i]}) begin failures++; $display("FAIL msb_ser i=%0d got=%b exp=%b", i, c_ser, {r2[i], r1[i], r0[i]}); end
      checks++; if (c_ser[0] !== (i == 0)) begin failures++; $display("FAIL msb_ch0 i=%0d got=%b", i, c_ser[0]); end
      checks++; if (c_clk[0] !== rc[i]) begin failures++; $display("FAIL msb_clk i=%0d got=%b exp=%b", i, c_clk[0], rc[i]); end
      checks++; if (c_ready !== (i == 9)) begin failures++; $display("FAIL msb_ready i=%0d got=%b", i, c_ready); end
    end
    c_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0] e [3];
    logic       v, exp_uf;
    reset_all();
    exp_uf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      a_valid = v;
      a_sym = {10'($urandom), 10'($urandom), 10'($urandom)};
      for (int k = 0; k < 3; k++) e[k] = v ? a_sym[10*k +: 10] : IDLE;
      if (!v) exp_uf = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step();
        if (i != 4) begin
          a_sym = {10'($urandom), 10'($urandom), 10'($urandom)};
          a_valid = 1'($urandom);
        end
        checks++; if (a_ser !== slice2(e[0], e[1], e[2], i)) begin failures++; $display("FAIL rand_ser n=%0d i=%0d got=%h exp=%h", n, i, a_ser, slice2(e[0], e[1], e[2], i)); end
        checks++; if (a_clk !== clkp_v[2*i +: 2]) begin failures++; $display("FAIL rand_clk n=%0d i=%0d got=%b exp=%b", n, i, a_clk, clkp_v[2*i +: 2]); end
        checks++; if (a_uf !== exp_uf) begin failures++; $display("FAIL rand_uf n=%0d i=%0d got=%b exp=%b", n, i, a_uf, exp_uf); end
        if (i == 4) begin
          checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rand_ready n=%0d got=%b exp=1", n, a_ready); end
        end
      end
    end
    a_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_reset_mid();
    test_wide();
    test_msb_first();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
